sleep_responder: RTL and testbench

- Callee side of the generated-FSM subroutine handshake for the `sleep` call. It pairs with the caller-side `__p_ms_sleep`, `__start_sleep`, `__idle_sleep` and `__valid_sleep` ports.
- Takes a millisecond count with a one-cycle start pulse, waits that long in clock cycles, then reports completion with a one-cycle valid pulse.
- Sits beside any generated caller module and is wired port-to-port to its sleep interface.

---
 rtl/sleep_responder.sv | 96 +++++++++
 tb/tb_sleep_responder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sleep_responder.sv
// Callee side of the sleep subroutine handshake: waits __p_ms milliseconds of
// clk cycles, then pulses __valid. Optional early abort under SLEEP_RESPONDER_ABORT_EN.
module sleep_responder #(
  parameter int unsigned CYCLES_PER_MS = 50000,
  parameter int          TICK_W        = $clog2(CYCLES_PER_MS + 1)
) (
  input  logic        __clk,
  input  logic        __reset,
  input  logic [31:0] __p_ms,
  input  logic        __start,
`ifdef SLEEP_RESPONDER_ABORT_EN
  input  logic        __abort,
`endif
  output logic        __idle,
  output logic        __valid
);

  if (CYCLES_PER_MS < 1) begin : g_bad_cycles_per_ms
    $error("sleep_responder: CYCLES_PER_MS must be at least 1");
  end

  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(CYCLES_PER_MS - 1);
  localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [31:0]       r_ms_left;
  logic [31:0]       w_ms_left_next;
  logic [TICK_W-1:0] r_tick;
  logic [TICK_W-1:0] w_tick_next;
  logic              w_abort;

`ifdef SLEEP_RESPONDER_ABORT_EN
  assign w_abort = __abort;
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge __clk) begin
    if (__reset) begin
      r_state   <= IDLE;
      r_ms_left <= 32'd0;
      r_tick    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_ms_left <= w_ms_left_next;
      r_tick    <= w_tick_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_ms_left_next = r_ms_left;
    w_tick_next    = r_tick;
    case (r_state)
      IDLE: begin
        if (__start) begin
          w_ms_left_next = __p_ms;
          w_tick_next    = '0;
          w_state_next   = (__p_ms == 32'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_abort) begin
          w_tick_next  = '0;
          w_state_next = DONE;
        end else if (r_tick == TICK_MAX) begin
          // One millisecond elapsed; the last one ends the call.
          w_tick_next    = '0;
          w_ms_left_next = r_ms_left - 32'd1;
          if (r_ms_left == 32'd1) begin
            w_state_next = DONE;
          end
        end else begin
          w_tick_next = r_tick + TICK_ONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign __idle  = (r_state == IDLE);
  assign __valid = (r_state == DONE);

endmodule

// File: tb/tb_sleep_responder.sv
// Directed bench for sleep_responder: one instance at 4 cycles/ms, one at 1 cycle/ms.
module tb_sleep_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] p_ms4, p_ms1;
  logic        start4, start1;
  logic        abort4, abort1;
  logic        idle4, valid4, idle1, valid1;

  int passed = 0;
  int total  = 0;
  int w_cnt;
  int w_first;

  always #5 clk = ~clk;

  sleep_responder #(.CYCLES_PER_MS(4)) u_dut4 (
    .__clk   (clk),
    .__reset (rst),
    .__p_ms  (p_ms4),
    .__start (start4),
`ifdef SLEEP_RESPONDER_ABORT_EN
    .__abort (abort4),
`endif
    .__idle  (idle4),
    .__valid (valid4)
  );

  sleep_responder #(.CYCLES_PER_MS(1)) u_dut1 (
    .__clk   (clk),
    .__reset (rst),
    .__p_ms  (p_ms1),
    .__start (start1),
`ifdef SLEEP_RESPONDER_ABORT_EN
    .__abort (abort1),
`endif
    .__idle  (idle1),
    .__valid (valid1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %-22s obs=%0d exp=%0d", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start on one instance; returns just after the accepting edge E.
  task automatic start_call(input bit sel1, input logic [31:0] ms);
    if (sel1) begin p_ms1 = ms; start1 = 1'b1; end
    else      begin p_ms4 = ms; start4 = 1'b1; end
    step();
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  // Watch n edges; w_first = index of first edge after which __valid was high.
  task automatic watch(input bit sel1, input int n);
    w_cnt   = 0;
    w_first = -1;
    for (int i = 1; i <= n; i++) begin
      step();
      if (sel1 ? valid1 : valid4) begin
        w_cnt++;
        if (w_first < 0) w_first = i;
      end
    end
  endtask

  initial begin
    rst = 1'b1; p_ms4 = 0; p_ms1 = 0;
    start4 = 0; start1 = 0; abort4 = 0; abort1 = 0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset_idle4", idle4, 1);
    chk("reset_valid4", valid4, 0);
    chk("reset_idle1", idle1, 1);
    chk("reset_valid1", valid1, 0);

    // 3 ms at 4 cycles/ms: DONE after edge E+12
    start_call(1'b0, 32'd3);
    chk("ms3_idle_low", idle4, 0);
    watch(1'b0, 12);
    chk("ms3_first_valid", w_first, 12);
    chk("ms3_valid_count", w_cnt, 1);
    chk("ms3_done_idle_low", idle4, 0);
    step();
    chk("ms3_idle_back", idle4, 1);
    chk("ms3_valid_gone", valid4, 0);

    // zero delay goes straight to DONE
    start_call(1'b0, 32'd0);
    chk("ms0_valid", valid4, 1);
    chk("ms0_idle_low", idle4, 0);
    step();
    chk("ms0_idle_back", idle4, 1);
    watch(1'b0, 5);
    chk("ms0_no_extra_valid", w_cnt, 0);

    // start and p_ms change during RUN are ignored
    start_call(1'b0, 32'd2);
    watch(1'b0, 2);
    chk("ign_no_early_valid", w_cnt, 0);
    p_ms4 = 32'd9; start4 = 1'b1;
    step();
    start4 = 1'b0;
    chk("ign_edge3_valid", valid4, 0);
    watch(1'b0, 10);
    chk("ign_first_valid", w_first, 5);
    chk("ign_valid_count", w_cnt, 1);
    chk("ign_idle_after", idle4, 1);

    // reset in the middle of a 5 ms call
    start_call(1'b0, 32'd5);
    watch(1'b0, 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_idle", idle4, 1);
    watch(1'b0, 30);
    chk("midrst_no_valid", w_cnt, 0);
    start_call(1'b0, 32'd1);
    watch(1'b0, 6);
    chk("fresh_first_valid", w_first, 4);
    chk("fresh_valid_count", w_cnt, 1);

    // 1 cycle/ms instance, then back-to-back call at first idle cycle
    start_call(1'b1, 32'd7);
    watch(1'b1, 7);
    chk("c1_first_valid", w_first, 7);
    chk("c1_valid_count", w_cnt, 1);
    step();
    chk("c1_idle_back", idle1, 1);
    start_call(1'b1, 32'd1);
    chk("b2b_idle_low", idle1, 0);
    chk("b2b_valid_low", valid1, 0);
    step();
    chk("b2b_valid", valid1, 1);
    step();
    chk("b2b_idle_back", idle1, 1);

`ifdef SLEEP_RESPONDER_ABORT_EN
    // abort sampled at edge E+10 of a 100 ms call
    start_call(1'b0, 32'd100);
    watch(1'b0, 9);
    chk("abort_no_early_valid", w_cnt, 0);
    abort4 = 1'b1;
    step();
    abort4 = 1'b0;
    chk("abort_valid", valid4, 1);
    step();
    chk("abort_idle_back", idle4, 1);
    chk("abort_valid_gone", valid4, 0);
    abort4 = 1'b1;
    watch(1'b0, 3);
    chk("abort_idle_no_valid", w_cnt, 0);
    chk("abort_idle_stays", idle4, 1);
    start_call(1'b0, 32'd1);
    abort4 = 1'b0;
    chk("abort_start_accepted", idle4, 0);
    chk("abort_start_no_valid", valid4, 0);
    watch(1'b0, 6);
    chk("abort_start_first", w_first, 4);
    chk("abort_start_count", w_cnt, 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
